mem_copy_master: RTL and testbench
==================================

// Module: mem_copy_master
// PURPOSE
//   Initiator for the single-cycle DataMemory port. Copies a block of Count words from SrcAddr to
//   DstAddr, one read followed by one write per word, and keeps a running checksum of the words copied.
//   It drives the memory port when the processor is not using it (the top level multiplexes on busy).
//   It is used for test-image loading and array moves in the single-cycle system.
// PARAMETERS
//   data_bus_size  32  width of Address, DWriteData, DReadData, SrcAddr, DstAddr, Checksum
//   CNT_W          4   width of Count (maximum block length is 2**CNT_W-1 words)
//   ADDR_STEP      1   pointer increment per word (word addressing; memory decodes Address[2:0])
// PORTS
//   clock       in   1               system clock, all state updates on posedge
//   reset       in   1               synchronous, active-high
//   start       in   1               request a copy; sampled only in IDLE
//   SrcAddr     in   data_bus_size   first source word address, latched on accepted start
//   DstAddr     in   data_bus_size   first destination word address, latched on accepted start
//   Count       in   CNT_W           number of words, latched on accepted start
//   busy        out  1               high in RD and WR states
//   done        out  1               one-cycle pulse in DONE state
//   Checksum    out  data_bus_size   sum mod 2**data_bus_size of words copied by the last/current job
//   Address     out  data_bus_size   memory address
//   DWriteData  out  data_bus_size   memory write data
//   MemRead     out  1               high in RD
//   MemWrite    out  1               high in WR
//   DReadData   in   data_bus_size   memory read data, combinational from Address (same cycle)
// BEHAVIOUR
//   Reset (synchronous, on posedge with reset=1):
//     - state=IDLE; pointers, remaining count, data buffer and Checksum = 0.
//     - Outputs: busy=0, done=0, MemRead=0, MemWrite=0, Address=0, DWriteData=0.
//     - Reset takes priority over everything, including mid-job: a write in progress is not committed
//       by this block, because MemWrite is low from the next cycle.
//   FSM states: IDLE, RD, WR, DONE.
//     - IDLE: if start=1, latch src<=SrcAddr, dst<=DstAddr, rem<=Count, Checksum<=0.
//       Go to DONE if Count==0, else go to RD.
//     - RD: Address=src, MemRead=1. On the edge: buf<=DReadData, Checksum<=Checksum+DReadData,
//       src<=src+ADDR_STEP; go to WR.
//     - WR: Address=dst, DWriteData=buf, MemWrite=1 (the memory commits on this edge).
//       On the edge: dst<=dst+ADDR_STEP, rem<=rem-1; go to DONE if rem==1, else go to RD.
//     - DONE: done=1 for exactly one cycle, busy=0; go to IDLE. Checksum holds until the next accepted start.
//   Outputs in IDLE/DONE: MemRead=0, MemWrite=0, Address=0, DWriteData=0.
//   MemRead and MemWrite are never high in the same cycle.
//   Latency: with the start edge at edge 0, the job runs RD/WR pairs in cycles 1..2N and done is high in
//     cycle 2N+1. For Count=0, done is high in cycle 1 and there are no memory accesses.
//   Start handling:
//     - start while busy or in DONE is ignored; it is not queued.
//     - start may be held high; a new job is accepted on each visit to IDLE.
//   Arithmetic and ordering:
//     - Pointers wrap modulo 2**data_bus_size (0xFFFFFFFF+1 -> 0).
//     - The checksum addition discards the carry.
//     - Words are copied in ascending order with no overlap detection; an overlapping forward copy
//       propagates already-written data by design.
//   Inputs SrcAddr/DstAddr/Count may change freely after the accepted start.
// TESTING
//   1 reset: assert reset for 2 cycles mid-job -> next cycle busy=0, MemWrite=0, Checksum=0, state IDLE.
//   2 copy: memory at reset, Src=0, Dst=4, Count=2 -> WR cycles drive (4,0x5) and (5,0xA);
//     DMem[4]=0x5, DMem[5]=0xA; done in cycle 5; Checksum=0xF.
//   3 zero length: Count=0, start -> done in cycle 1, MemRead/MemWrite never high, Checksum=0.
//   4 busy start: pulse start with new Src during cycle 2 of a 3-word job -> ignored;
//     exactly 6 busy cycles, then one done.
//   5 wrap: Src=7, Dst=0xFFFFFFFF, Count=2 -> reads Address 7 then 8 (DMem[0]); writes 0xFFFFFFFF then 0;
//     Checksum=0x4444+0x5=0x4449.
//   6 checksum overflow: words 0xFFFFFFFF, 0x00000002 copied -> Checksum=0x00000001.

Source files
------------

// File: rtl/mem_copy_master.sv
// Block-copy initiator for the single-cycle data memory port.
// Copies Count words from SrcAddr to DstAddr (one read, then one write per word)
// and accumulates a wrap-around checksum of the words moved.
module mem_copy_master #(
  parameter int data_bus_size = 32,
  parameter int CNT_W         = 4,
  parameter int ADDR_STEP     = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [data_bus_size-1:0] SrcAddr,
  input  logic [data_bus_size-1:0] DstAddr,
  input  logic [CNT_W-1:0]         Count,
  output logic                     busy,
  output logic                     done,
  output logic [data_bus_size-1:0] Checksum,
  output logic [data_bus_size-1:0] Address,
  output logic [data_bus_size-1:0] DWriteData,
  output logic                     MemRead,
  output logic                     MemWrite,
  input  logic [data_bus_size-1:0] DReadData
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [data_bus_size-1:0] STEP = data_bus_size'(ADDR_STEP);
  localparam logic [CNT_W-1:0]         ONE  = CNT_W'(1);

  state_t                   state, next_state;
  logic [data_bus_size-1:0] src, dst, data_buf;
  logic [CNT_W-1:0]         rem;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode and memory-port drive; the port is idle (all zero) outside RD/WR
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    DWriteData = '0;
    case (state)
      IDLE: begin
        if (start) next_state = (Count == '0) ? DONE : RD;
      end
      RD: begin
        busy       = 1'b1;
        MemRead    = 1'b1;
        Address    = src;
        next_state = WR;
      end
      WR: begin
        busy       = 1'b1;
        MemWrite   = 1'b1;
        Address    = dst;
        DWriteData = data_buf;
        next_state = (rem == ONE) ? DONE : RD;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Job datapath: latch job on accepted start, capture/accumulate on reads, advance on writes
  always_ff @(posedge clock) begin
    if (reset) begin
      src      <= '0;
      dst      <= '0;
      rem      <= '0;
      data_buf <= '0;
      Checksum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src      <= SrcAddr;
            dst      <= DstAddr;
            rem      <= Count;
            Checksum <= '0;
          end
        end
        RD: begin
          data_buf <= DReadData;
          Checksum <= Checksum + DReadData;
          src      <= src + STEP;
        end
        WR: begin
          dst <= dst + STEP;
          rem <= rem - ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed testbench for mem_copy_master with an 8-word memory decoded on Address[2:0].
`timescale 1ns/1ps
module tb_mem_copy_master;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] SrcAddr, DstAddr;
  logic [3:0]  Count;
  logic        busy, done, MemRead, MemWrite;
  logic [31:0] Checksum, Address, DWriteData, DReadData;

  logic        mem_load;
  logic        mem_img;
  logic [31:0] mem [8];

  int checks;
  int failures;

  mem_copy_master #(.data_bus_size(32), .CNT_W(4), .ADDR_STEP(1)) dut (
    .clock(clock), .reset(reset), .start(start),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Count(Count),
    .busy(busy), .done(done), .Checksum(Checksum),
    .Address(Address), .DWriteData(DWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .DReadData(DReadData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] img_word(input logic img, input int i);
    logic [31:0] w;
    w = 32'h0;
    if (!img) begin
      if (i == 0) w = 32'h5;
      if (i == 1) w = 32'hA;
      if (i == 7) w = 32'h4444;
    end else begin
      if (i == 2) w = 32'hFFFF_FFFF;
      if (i == 3) w = 32'h0000_0002;
    end
    return w;
  endfunction

  // Single-cycle memory: combinational read, write committed on the edge
  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 8; i++) mem[i] <= img_word(mem_img, i);
    end else if (MemWrite) begin
      mem[Address[2:0]] <= DWriteData;
    end
  end

  assign DReadData = mem[Address[2:0]];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_mem(input logic img);
    mem_img  = img;
    mem_load = 1'b1;
    step();
    mem_load = 1'b0;
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [3:0] n);
    SrcAddr = s;
    DstAddr = d;
    Count   = n;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    load_mem(1'b0);
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({MemRead, MemWrite} !== 2'b00) begin failures++; $display("FAIL reset_mem_ctl got=%b exp=00", {MemRead, MemWrite}); end
    checks++; if (Address !== 32'h0 || DWriteData !== 32'h0) begin failures++; $display("FAIL reset_port got=%h/%h exp=0/0", Address, DWriteData); end
    checks++; if (Checksum !== 32'h0) begin failures++; $display("FAIL reset_checksum got=%h exp=0", Checksum); end
  endtask

  task automatic test_reset_midjob();
    load_mem(1'b0);
    start_job(32'h0, 32'h4, 4'd3);
    step();
    checks++; if (MemWrite !== 1'b1 || Checksum !== 32'h5) begin failures++; $display("FAIL midjob_pre got=%b/%h exp=1/5", MemWrite, Checksum); end
    reset = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || MemWrite !== 1'b0 || Checksum !== 32'h0) begin failures++; $display("FAIL midjob_reset got=%b/%b/%h exp=0/0/0", busy, MemWrite, Checksum); end
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (busy !== 1'b0 || done !== 1'b0 || MemRead !== 1'b0) begin failures++; $display("FAIL midjob_idle c=%0d got=%b/%b/%b exp=0/0/0", c, busy, done, MemRead); end
      step();
    end
  endtask

  task automatic test_copy();
    load_mem(1'b0);
    start_job(32'h0, 32'h4, 4'd2);
    checks++; if (!(MemRead && !MemWrite && busy && Address == 32'h0)) begin failures++; $display("FAIL copy_c1 got=%b%b%b addr=%h exp=101 addr=0", MemRead, MemWrite, busy, Address); end
    step();
    checks++; if (!(MemWrite && !MemRead && Address == 32'h4 && DWriteData == 32'h5)) begin failures++; $display("FAIL copy_c2 got=%b%b %h,%h exp=01 4,5", MemRead, MemWrite, Address, DWriteData); end
    step();
    checks++; if (!(MemRead && Address == 32'h1)) begin failures++; $display("FAIL copy_c3 got=%b addr=%h exp=1 addr=1", MemRead, Address); end
    step();
    checks++; if (!(MemWrite && Address == 32'h5 && DWriteData == 32'hA)) begin failures++; $display("FAIL copy_c4 got=%b %h,%h exp=1 5,a", MemWrite, Address, DWriteData); end
    step();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL copy_done got=%b/%b exp=1/0", done, busy); end
    checks++; if (Checksum !== 32'hF) begin failures++; $display("FAIL copy_checksum got=%h exp=f", Checksum); end
    checks++; if (mem[4] !== 32'h5 || mem[5] !== 32'hA) begin failures++; $display("FAIL copy_mem got=%h,%h exp=5,a", mem[4], mem[5]); end
    step();
    checks++; if (done !== 1'b0 || Checksum !== 32'hF) begin failures++; $display("FAIL copy_after got=%b/%h exp=0/f", done, Checksum); end
  endtask

  task automatic test_zero_length();
    int rw;
    rw = 0;
    start_job(32'h3, 32'h6, 4'd0);
    if (MemRead || MemWrite) rw++;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_done got=%b/%b exp=1/0", done, busy); end
    checks++; if (Checksum !== 32'h0) begin failures++; $display("FAIL zero_checksum got=%h exp=0", Checksum); end
    for (int c = 0; c < 3; c++) begin
      step();
      if (MemRead || MemWrite || done) rw++;
    end
    checks++; if (rw !== 0) begin failures++; $display("FAIL zero_activity got=%0d exp=0", rw); end
  endtask

  task automatic test_busy_start();
    int nbusy, ndone;
    load_mem(1'b0);
    start_job(32'h0, 32'h4, 4'd3);
    nbusy = busy ? 1 : 0;
    ndone = done ? 1 : 0;
    step();
    SrcAddr = 32'h6;
    Count   = 4'd1;
    start   = 1'b1;
    if (busy) nbusy++;
    step();
    start = 1'b0;
    checks++; if (!(MemRead && Address == 32'h1)) begin failures++; $display("FAIL busy_src got=%b addr=%h exp=1 addr=1", MemRead, Address); end
    for (int c = 3; c <= 12; c++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      step();
    end
    checks++; if (nbusy !== 6) begin failures++; $display("FAIL busy_cycles got=%0d exp=6", nbusy); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_held_start();
    logic [7:0] done_map, busy_map;
    done_map = '0;
    busy_map = '0;
    SrcAddr = 32'h0;
    DstAddr = 32'h4;
    Count   = 4'd1;
    start   = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      done_map[c] = done;
      busy_map[c] = busy;
    end
    start = 1'b0;
    checks++; if (done_map !== 8'b1000_1000) begin failures++; $display("FAIL held_done got=%b exp=10001000", done_map); end
    checks++; if (busy_map !== 8'b0110_0110) begin failures++; $display("FAIL held_busy got=%b exp=01100110", busy_map); end
    step();
    step();
  endtask

  task automatic test_wrap();
    load_mem(1'b0);
    start_job(32'h7, 32'hFFFF_FFFF, 4'd2);
    checks++; if (!(MemRead && Address == 32'h7 && DReadData == 32'h4444)) begin failures++; $display("FAIL wrap_rd1 got=%b %h,%h exp=1 7,4444", MemRead, Address, DReadData); end
    step();
    checks++; if (!(MemWrite && Address == 32'hFFFF_FFFF && DWriteData == 32'h4444)) begin failures++; $display("FAIL wrap_wr1 got=%b %h,%h exp=1 ffffffff,4444", MemWrite, Address, DWriteData); end
    step();
    checks++; if (!(MemRead && Address == 32'h8)) begin failures++; $display("FAIL wrap_rd2 got=%b addr=%h exp=1 addr=8", MemRead, Address); end
    step();
    checks++; if (!(MemWrite && Address == 32'h0 && DWriteData == 32'h5)) begin failures++; $display("FAIL wrap_wr2 got=%b %h,%h exp=1 0,5", MemWrite, Address, DWriteData); end
    step();
    checks++; if (done !== 1'b1 || Checksum !== 32'h4449) begin failures++; $display("FAIL wrap_checksum got=%b/%h exp=1/4449", done, Checksum); end
    step();
  endtask

  task automatic test_checksum_overflow();
    load_mem(1'b1);
    start_job(32'h2, 32'h6, 4'd2);
    step();
    checks++; if (Checksum !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ovf_partial got=%h exp=ffffffff", Checksum); end
    step();
    step();
    step();
    checks++; if (done !== 1'b1 || Checksum !== 32'h1) begin failures++; $display("FAIL ovf_checksum got=%b/%h exp=1/1", done, Checksum); end
    checks++; if (mem[6] !== 32'hFFFF_FFFF || mem[7] !== 32'h2) begin failures++; $display("FAIL ovf_mem got=%h,%h exp=ffffffff,2", mem[6], mem[7]); end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    SrcAddr  = '0;
    DstAddr  = '0;
    Count    = '0;
    mem_load = 1'b0;
    mem_img  = 1'b0;
    test_reset();
    test_reset_midjob();
    test_copy();
    test_zero_length();
    test_busy_start();
    test_held_start();
    test_wrap();
    test_checksum_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
